// File: rtl/fp32_add_issue_pkg.sv
// rtl/fp32_add_issue_pkg.sv - fp32 type and field helpers shared by the fp32_add issue stage
package fp32_add_issue_pkg;

    typedef logic [31:0] fp32_t;

    function automatic logic fp32_sign(input fp32_t x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp32_exp(input fp32_t x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp32_mant(input fp32_t x);
        return x[22:0];
    endfunction

    function automatic logic fp32_is_subnormal(input fp32_t x);
        return (fp32_exp(x) == 8'd0) && (fp32_mant(x) != 23'd0);
    endfunction

    // Subnormals become a zero of the same sign; everything else passes through.
    function automatic fp32_t fp32_ftz(input fp32_t x);
        return fp32_is_subnormal(x) ? {fp32_sign(x), 31'd0} : x;
    endfunction

endpackage

// File: rtl/fp32_issue_fifo.sv
// rtl/fp32_issue_fifo.sv - parameterised synchronous FIFO with occupancy count
module fp32_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fp32_add_issue.sv
// rtl/fp32_add_issue.sv - credit-tracked issue stage for fp32_add; FP32_ISSUE_FTZ_EN flushes subnormal operands
module fp32_add_issue
    import fp32_add_issue_pkg::*;
#(
    parameter int ADD_LATENCY = 11,
    parameter int FIFO_DEPTH  = 16,
    parameter int TAG_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             add_op_vld,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic             add_result_vld,
    input  logic [31:0]      add_result,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             err_stray
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int FCW = $clog2(ADD_LATENCY + 1);
    localparam logic [CW-1:0]  DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [FCW-1:0] FLUSH_CNT = FCW'(ADD_LATENCY);

    typedef enum logic {FLUSH, RUN} state_t;

    state_t           state;
    logic [FCW-1:0]   flush_cnt;
    logic [CW-1:0]    in_flight;
    logic [CW-1:0]    res_count;
    logic [CW-1:0]    credits;
    logic             accept;
    logic             ret_ok;
    logic             stray;
    logic             res_empty;
    logic             tag_empty;
    logic [TAG_W-1:0] tag_head;
    fp32_t            a_cond;
    fp32_t            b_cond;
    logic             unused_tag_full;
    logic             unused_res_full;
    logic [CW-1:0]    unused_tag_count;

`ifdef FP32_ISSUE_FTZ_EN
    assign a_cond = fp32_ftz(in_a);
    assign b_cond = fp32_ftz(in_b);
`else
    assign a_cond = in_a;
    assign b_cond = in_b;
`endif

    // Every slot is either holding a result or reserved by an operation in the adder.
    assign credits = DEPTH_CNT - res_count - in_flight;
    assign in_rdy  = (state == RUN) && (credits != '0);
    assign accept  = in_vld && in_rdy;
    assign ret_ok  = add_result_vld && (state == RUN) && (in_flight != '0) && !tag_empty;
    assign stray   = add_result_vld && (state == RUN) && (in_flight == '0);
    assign out_vld = !res_empty;

    // Drain leftover adder pipeline contents after reset before accepting work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_CNT;
        end else begin
            case (state)
                FLUSH: begin
                    if (flush_cnt == '0) state <= RUN;
                    else                 flush_cnt <= flush_cnt - 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Register accepted operands toward the adder as a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_op_vld <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
        end else begin
            add_op_vld <= accept;
            if (accept) begin
                add_a <= a_cond;
                add_b <= b_cond;
            end
        end
    end

    // Count operations issued but not yet returned by the adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            case ({accept, ret_ok})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Sticky flag for a result arriving with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     err_stray <= 1'b0;
        else if (stray) err_stray <= 1'b1;
    end

    // Tags wait here in issue order until their result comes back.
    fp32_issue_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (in_tag),
        .pop       (ret_ok),
        .pop_data  (tag_head),
        .empty     (tag_empty),
        .full      (unused_tag_full),
        .count     (unused_tag_count)
    );

    // Results are stored already paired with the tag at the head of the tag FIFO.
    fp32_issue_fifo #(
        .WIDTH (32 + TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ret_ok),
        .push_data ({tag_head, add_result}),
        .pop       (out_vld && out_rdy),
        .pop_data  ({out_tag, out_result}),
        .empty     (res_empty),
        .full      (unused_res_full),
        .count     (res_count)
    );

endmodule

// File: tb/tb_fp32_add_issue.sv
// tb/tb_fp32_add_issue.sv - scoreboard bench for fp32_add_issue with a fixed-latency adder model
module tb_fp32_add_issue;

    localparam int LAT   = 11;
    localparam int DEPTH = 16;
    localparam int TW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [31:0]   in_a = '0;
    logic [31:0]   in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          add_op_vld;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic          add_result_vld;
    logic [31:0]   add_result;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [31:0]   out_result;
    logic [TW-1:0] out_tag;
    logic          err_stray;

    logic          inj_vld = 1'b0;
    logic [31:0]   inj_data = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [TW+31:0] q[$];
    logic [31:0] cap_a = '0;
    logic [31:0] cap_b = '0;

    always #5 clk = ~clk;

    fp32_add_issue #(
        .ADD_LATENCY (LAT),
        .FIFO_DEPTH  (DEPTH),
        .TAG_W       (TW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_tag         (in_tag),
        .add_op_vld     (add_op_vld),
        .add_a          (add_a),
        .add_b          (add_b),
        .add_result_vld (add_result_vld),
        .add_result     (add_result),
        .out_vld        (out_vld),
        .out_rdy        (out_rdy),
        .out_result     (out_result),
        .out_tag        (out_tag),
        .err_stray      (err_stray)
    );

    // Exact for integer-valued fp32 inputs below 2^24; subnormals read as zero.
    function automatic int fp2int(input logic [31:0] x);
        int e;
        int m;
        e = int'(x[30:23]);
        if (e < 127) return 0;
        m = int'({1'b1, x[22:0]});
        m = m >> (23 - (e - 127));
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] int2fp(input int n);
        logic s;
        int   u;
        int   p;
        if (n == 0) return 32'h0;
        s = (n < 0);
        u = s ? -n : n;
        p = 0;
        while ((u >> (p + 1)) != 0) p++;
        return {s, 8'(127 + p), 23'((u << (23 - p)) & 32'h7FFFFF)};
    endfunction

    logic [LAT-1:0] pv = '0;
    logic [31:0]    pd [LAT];

    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], add_op_vld};
        pd[0] <= int2fp(fp2int(add_a) + fp2int(add_b));
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end

    assign add_result_vld = pv[LAT-1] | inj_vld;
    assign add_result     = inj_vld ? inj_data : pd[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (add_op_vld) begin
            cap_a = add_a;
            cap_b = add_b;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h/%0h expected nothing", out_result, out_tag);
            end else begin
                logic [TW+31:0] e;
                e = q.pop_front();
                chk("out_result", {32'd0, out_result}, {32'd0, e[31:0]});
                chk("out_tag", {56'd0, out_tag}, {56'd0, e[TW+31:32]});
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t,
                        input logic [31:0] exp_r);
        int n;
        in_a = a; in_b = b; in_tag = t; in_vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_rdy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", {63'd0, in_rdy}, 64'd1);
        if (in_rdy) q.push_back({t, exp_r});
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int drops;
        int acc;

        repeat (3) @(negedge clk);
        chk("rst_in_rdy", {63'd0, in_rdy}, 64'd0);
        chk("rst_add_op_vld", {63'd0, add_op_vld}, 64'd0);
        chk("rst_add_a", {32'd0, add_a}, 64'd0);
        chk("rst_add_b", {32'd0, add_b}, 64'd0);
        chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
        chk("rst_err_stray", {63'd0, err_stray}, 64'd0);

        // Flush window: count cycles with in_rdy low, injecting one leftover result.
        rst_n = 1'b1;
        n = 0;
        while (!in_rdy && n < 40) begin
            inj_data = 32'hDEADBEEF;
            inj_vld  = (n == 5);
            n++;
            @(negedge clk);
        end
        inj_vld = 1'b0;
        chk("flush_cycles", 64'(n), 64'd12);
        chk("flush_err_stray", {63'd0, err_stray}, 64'd0);
        chk("flush_out_vld", {63'd0, out_vld}, 64'd0);

        // Single op latency: 1.0 + 2.0.
        @(posedge clk); #1;
        in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 8'h5A; in_vld = 1'b1;
        @(negedge clk);
        chk("lat_in_rdy", {63'd0, in_rdy}, 64'd1);
        if (in_rdy) q.push_back({8'h5A, 32'h40400000});
        @(posedge clk); #1;
        in_vld = 1'b0;
        k = 1;
        @(negedge clk);
        while (!out_vld && k < 40) begin
            k++;
            @(negedge clk);
        end
        chk("latency", 64'(k), 64'(LAT + 2));
        wait_drain();

        // 64 back-to-back operations with the consumer always ready.
        @(posedge clk); #1;
        drops = 0;
        for (int i = 0; i < 64; i++) begin
            in_a = int2fp(i + 1); in_b = int2fp(2 * (i + 1)); in_tag = 8'(i); in_vld = 1'b1;
            @(negedge clk);
            if (!in_rdy) begin
                drops++;
                n = 0;
                while (!in_rdy && n < 50) begin
                    n++;
                    @(negedge clk);
                end
            end
            if (in_rdy) q.push_back({8'(i), int2fp(3 * (i + 1))});
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        chk("stream_drops", 64'(drops), 64'd0);
        wait_drain();

        // Backpressure: consumer stalled, only FIFO_DEPTH operations may be accepted.
        @(posedge clk); #1;
        out_rdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 60; c++) begin
            in_a = int2fp(acc + 100); in_b = int2fp(acc); in_tag = 8'(8'h80 + acc); in_vld = 1'b1;
            @(negedge clk);
            if (in_rdy) begin
                q.push_back({8'(8'h80 + acc), int2fp(2 * acc + 100)});
                acc++;
            end
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        @(negedge clk);
        chk("bp_accepted", 64'(acc), 64'(DEPTH));
        chk("bp_in_rdy", {63'd0, in_rdy}, 64'd0);
        chk("bp_out_vld", {63'd0, out_vld}, 64'd1);
        if (q.size() != 0) begin
            chk("bp_head_result", {32'd0, out_result}, {32'd0, q[0][31:0]});
            chk("bp_head_tag", {56'd0, out_tag}, {56'd0, q[0][TW+31:32]});
        end
        out_rdy = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("bp_in_rdy_back", {63'd0, in_rdy}, 64'd1);

        // Stray result with nothing in flight.
        repeat (4) @(negedge clk);
        inj_data = 32'h12345678;
        inj_vld  = 1'b1;
        @(negedge clk);
        inj_vld  = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_err", {63'd0, err_stray}, 64'd1);
        chk("stray_out_vld", {63'd0, out_vld}, 64'd0);
        chk("stray_in_rdy", {63'd0, in_rdy}, 64'd1);

        // Subnormal operand handling.
        @(posedge clk); #1;
        send(32'h80000001, 32'h3F800000, 8'hC3, 32'h3F800000);
        repeat (2) @(negedge clk);
`ifdef FP32_ISSUE_FTZ_EN
        chk("ftz_add_a", {32'd0, cap_a}, 64'h80000000);
`else
        chk("ftz_add_a", {32'd0, cap_a}, 64'h80000001);
`endif
        chk("ftz_add_b", {32'd0, cap_b}, 64'h3F800000);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
